// File: rtl/fp_mult_scheduler_if.sv
// fp_mult_scheduler_if: requester/result bus of the shared multiplier; FPM_SCHED_OVF_STICKY_EN adds ovf_sticky/ovf_clr
interface fp_mult_scheduler_if;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic        res0_valid;
    logic        res1_valid;
    logic        res0_ready;
    logic        res1_ready;
    logic [31:0] res_data;
    logic        res_ovf;
    logic        busy;
`ifdef FPM_SCHED_OVF_STICKY_EN
    logic [1:0]  ovf_sticky;
    logic        ovf_clr;
`endif

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res0_ready, res1_ready,
`ifdef FPM_SCHED_OVF_STICKY_EN
        output ovf_clr,
        input  ovf_sticky,
`endif
        input  req0_ready, req1_ready, res0_valid, res1_valid, res_data, res_ovf, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res0_ready, res1_ready,
`ifdef FPM_SCHED_OVF_STICKY_EN
        input  ovf_clr,
        output ovf_sticky,
`endif
        output req0_ready, req1_ready, res0_valid, res1_valid, res_data, res_ovf, busy
    );
endinterface

// File: rtl/fp_mult_scheduler.sv
// fp_mult_scheduler: one FP32 multiplier shared round-robin by two requesters; FPM_SCHED_OVF_STICKY_EN adds per-requester sticky overflow flags
module fp_mult_scheduler #(
    parameter int LAT = 2
) (
    input logic                 clk,
    input logic                 rst,
    fp_mult_scheduler_if.slave  io_bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             r_state;
    logic               r_last;
    logic               r_own;
    logic [1:0]         r_cnt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_res;
    logic               r_ovf;
    logic [1:0]         r_rv;

    logic               w_gnt;
    logic               w_idle;
    logic               w_acc;
    logic               w_del;
    logic               w_s;
    logic               w_zero;
    logic               w_povf;
    logic               w_unf;
    logic [47:0]        w_p;
    logic signed [9:0]  w_e;
    logic [22:0]        w_m;
    logic [31:0]        w_prod;

    // Multiplier fed only from captured operands; denormals count as zero and the mantissa is truncated
    always_comb begin
        w_p    = {1'b1, r_a[22:0]} * {1'b1, r_b[22:0]};
        w_s    = r_a[31] ^ r_b[31];
        w_e    = $signed({2'b0, r_a[30:23]}) + $signed({2'b0, r_b[30:23]}) - 10'sd127 + $signed({9'b0, w_p[47]});
        w_m    = w_p[47] ? w_p[46:24] : w_p[45:23];
        w_zero = (r_a[30:23] == 8'd0) || (r_b[30:23] == 8'd0);
        w_povf = !w_zero && (w_e > 10'sd254);
        w_unf  = !w_zero && (w_e < 10'sd1);
        w_prod = (w_zero || w_unf) ? 32'd0 : w_povf ? {w_s, 8'hFF, 23'd0} : {w_s, w_e[7:0], w_m};
    end

    // Grant: lone requester wins, on contention the one not granted last wins
    always_comb begin
        w_gnt  = (io_bus.req0_valid && io_bus.req1_valid) ? !r_last : io_bus.req1_valid;
        w_idle = (r_state == IDLE) && !rst;
        w_acc  = w_idle && (io_bus.req0_valid || io_bus.req1_valid);
        w_del  = (r_state == DONE) && (r_own ? io_bus.res1_ready : io_bus.res0_ready);
    end

    assign io_bus.req0_ready = w_idle && io_bus.req0_valid && !w_gnt;
    assign io_bus.req1_ready = w_idle && io_bus.req1_valid && w_gnt;
    assign io_bus.res0_valid = r_rv[0];
    assign io_bus.res1_valid = r_rv[1];
    assign io_bus.res_data   = r_res;
    assign io_bus.res_ovf    = r_ovf;
    assign io_bus.busy       = (r_state != IDLE);

    // Scheduler FSM: capture operands, count LAT busy cycles, hold result until the owner takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_own   <= 1'b0;
            r_cnt   <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_res   <= 32'd0;
            r_ovf   <= 1'b0;
            r_rv    <= 2'b00;
        end else begin
            case (r_state)
                IDLE: if (w_acc) begin
                    r_a     <= w_gnt ? io_bus.req1_a : io_bus.req0_a;
                    r_b     <= w_gnt ? io_bus.req1_b : io_bus.req0_b;
                    r_own   <= w_gnt;
                    r_last  <= w_gnt;
                    r_cnt   <= 2'd0;
                    r_state <= BUSY;
                end
                BUSY: if (r_cnt == 2'(LAT - 1)) begin
                    r_res   <= w_prod;
                    r_ovf   <= w_povf;
                    r_rv    <= r_own ? 2'b10 : 2'b01;
                    r_state <= DONE;
                end else begin
                    r_cnt   <= r_cnt + 2'd1;
                end
                DONE: if (w_del) begin
                    r_rv    <= 2'b00;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FPM_SCHED_OVF_STICKY_EN
    logic [1:0] r_sticky;

    assign io_bus.ovf_sticky = r_sticky;

    // Sticky overflow per requester, set on delivery; a same-cycle set beats the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 2'b00;
        end else begin
            r_sticky <= (io_bus.ovf_clr ? 2'b00 : r_sticky) | ((w_del && r_ovf) ? (r_own ? 2'b10 : 2'b01) : 2'b00);
        end
    end
`endif
endmodule

// File: tb/tb_fp_mult_scheduler.sv
// tb_fp_mult_scheduler: directed table plus hand sequences for fp_mult_scheduler; checks sticky flags when FPM_SCHED_OVF_STICKY_EN is defined
module tb_fp_mult_scheduler;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    fp_mult_scheduler_if bus();

    fp_mult_scheduler #(.LAT(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          n;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        o;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the accept edge: checks latency, result, and consumption
    task automatic collect(input bit n, input logic [31:0] d, input logic o, input string nm);
        for (int i = 1; i <= LAT; i++) begin
            tick();
            chk($sformatf("%s_rv0_c%0d", nm, i), 32'(bus.res0_valid), 32'((i == LAT) && !n));
            chk($sformatf("%s_rv1_c%0d", nm, i), 32'(bus.res1_valid), 32'((i == LAT) && n));
            chk($sformatf("%s_rdy_c%0d", nm, i), 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        end
        chk($sformatf("%s_data", nm), bus.res_data, d);
        chk($sformatf("%s_ovf", nm), 32'(bus.res_ovf), 32'(o));
        if (n) bus.res1_ready = 1'b1;
        else   bus.res0_ready = 1'b1;
        tick();
        bus.res0_ready = 1'b0;
        bus.res1_ready = 1'b0;
        chk($sformatf("%s_rv_drop", nm), 32'({bus.res1_valid, bus.res0_valid}), 32'd0);
        chk($sformatf("%s_idle", nm), 32'(bus.busy), 32'd0);
    endtask

    task automatic issue(input bit n, input logic [31:0] a, input logic [31:0] b, input logic [31:0] d, input logic o, input string nm);
        if (n) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        chk($sformatf("%s_ready", nm), 32'({bus.req1_ready, bus.req0_ready}), n ? 32'd2 : 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = 32'hDEADBEEF; bus.req0_b = 32'hDEADBEEF;
        bus.req1_a = 32'hDEADBEEF; bus.req1_b = 32'hDEADBEEF;
        chk($sformatf("%s_busy", nm), 32'(bus.busy), 32'd1);
        collect(n, d, o, nm);
    endtask

    initial begin
        tbl[0] = '{1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0};
        tbl[1] = '{1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0};
        tbl[2] = '{1'b0, 32'h00000000, 32'h40400000, 32'h00000000, 1'b0};
        tbl[3] = '{1'b1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1};
        tbl[4] = '{1'b0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0};
        tbl[5] = '{1'b1, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0};
        tbl[6] = '{1'b0, 32'hFF000000, 32'h7F000000, 32'hFF800000, 1'b1};
        tbl[7] = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0};

        bus.req0_valid = 1'b0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
        bus.res0_ready = 1'b0; bus.res1_ready = 1'b0;
`ifdef FPM_SCHED_OVF_STICKY_EN
        bus.ovf_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rv", 32'({bus.res1_valid, bus.res0_valid}), 32'd0);
        chk("rst_data", bus.res_data, 32'd0);
        chk("rst_ovf", 32'(bus.res_ovf), 32'd0);
        rst = 1'b0;
        tick();

        // Round-robin: both valid from reset, req0 first, then req1, then req0 again
        bus.req0_valid = 1'b1; bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h3FC00000;
        bus.req1_valid = 1'b1; bus.req1_a = 32'h40000000; bus.req1_b = 32'h40400000;
        #1;
        chk("rr1_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        collect(1'b0, 32'h40100000, 1'b0, "rr1");
        bus.req0_valid = 1'b1;
        #1;
        chk("rr2_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd2);
        tick();
        bus.req1_valid = 1'b0;
        collect(1'b1, 32'h40C00000, 1'b0, "rr2");
        bus.req1_valid = 1'b1;
        #1;
        chk("rr3_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        collect(1'b0, 32'h40100000, 1'b0, "rr3");

        for (int i = 0; i < 8; i++)
            issue(tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].o, $sformatf("v%0d", i));

`ifdef FPM_SCHED_OVF_STICKY_EN
        chk("stk_both", 32'(bus.ovf_sticky), 32'd3);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("stk_clr0", 32'(bus.ovf_sticky), 32'd0);
        issue(1'b1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, "stk");
        chk("stk_set", 32'(bus.ovf_sticky), 32'd2);
        repeat (3) tick();
        chk("stk_hold", 32'(bus.ovf_sticky), 32'd2);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("stk_clr1", 32'(bus.ovf_sticky), 32'd0);
`endif

        // Owner stalls five cycles while req1 waits and asserts the non-owner res_ready
        bus.req0_valid = 1'b1; bus.req0_a = 32'h40000000; bus.req0_b = 32'h40400000;
        tick();
        bus.req0_valid = 1'b0;
        repeat (LAT) tick();
        bus.req1_valid = 1'b1; bus.req1_a = 32'h3FC00000; bus.req1_b = 32'h3FC00000;
        bus.res1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_data_%0d", i), bus.res_data, 32'h40C00000);
            chk($sformatf("stall_rv_%0d", i), 32'({bus.res1_valid, bus.res0_valid}), 32'd1);
            chk($sformatf("stall_rdy_%0d", i), 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        end
        bus.res1_ready = 1'b0;
        bus.res0_ready = 1'b1;
        tick();
        bus.res0_ready = 1'b0;
        chk("stall_rdy_after", 32'({bus.req1_ready, bus.req0_ready}), 32'd2);
        tick();
        bus.req1_valid = 1'b0;
        collect(1'b1, 32'h40100000, 1'b0, "stall_req1");

        // Reset in the middle of BUSY abandons the operation
        bus.req0_valid = 1'b1; bus.req0_a = 32'h7F000000; bus.req0_b = 32'h7F000000;
        tick();
        bus.req0_valid = 1'b0;
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_data", bus.res_data, 32'd0);
        chk("mid_rst_out", 32'({bus.res_ovf, bus.res1_valid, bus.res0_valid, bus.req1_ready, bus.req0_ready}), 32'd0);
        bus.req0_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            chk($sformatf("post_rst_%0d", i), 32'({bus.busy, bus.res1_valid, bus.res0_valid}), 32'd0);
        end
        issue(1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, "post_rst_op");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
